sector_buffer_ram: RTL and testbench

- Parametrised single-clock, dual-port synchronous RAM for floppy sector buffering.
- Port A is a random-access host port with separate data in/out and one-cycle read latency.
- Port B is a streaming port with an auto-incrementing pointer, wrap-around, a valid/ready handshake and start/done control. It feeds or drains the MFM/track engine without host address generation.

---
 rtl/sector_buffer_ram.sv | 185 ++++++++++++++++++
 tb/tb_sector_buffer_ram.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sector_buffer_ram.sv
// Sector buffer RAM: single-clock dual-port memory for floppy sector data.
// Port A is a random-access host port with one-cycle read latency.
// Port B streams words to or from the MFM/track engine from an
// auto-incrementing, wrapping pointer under start/done control.
//
// Stream handshakes (both directions): a word moves on a rising edge only
// when the producer's valid and the consumer's ready are both high in that
// cycle. A producer holding valid keeps its data stable until the transfer
// happens, and valid never depends on ready.
//
// The port B FSM state is held in `state` (type b_state_t) so checkers can
// bind to it directly.
module sector_buffer_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    // Port A: host random access
    input  logic              a_cs,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    // Port B: streaming
    input  logic              b_start,
    input  logic              b_dir,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W:0]   b_len,
    input  logic [DATA_W-1:0] b_in_data,
    input  logic              b_in_valid,
    output logic              b_in_ready,
    output logic [DATA_W-1:0] b_out_data,
    output logic              b_out_valid,
    input  logic              b_out_ready,
    output logic              b_busy,
    output logic              b_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FETCH = 3'd1,
        RD_HOLD  = 3'd2,
        WR       = 3'd3,
        DONE     = 3'd4
    } b_state_t;

    // Storage is never reset; only control state is.
    logic [DATA_W-1:0] mem [DEPTH];

    b_state_t          state;
    b_state_t          state_n;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_n;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_n;
    logic              dir;
    logic              dir_n;

    // Port B memory strobes produced by the FSM.
    logic              b_rd_en;
    logic              b_wr_en;

    // Last-word detection: cnt is about to go from 1 to 0.
    logic              last_word;
    assign last_word = (cnt == (ADDR_W+1)'(1));

    // Memory writes: port B first, then port A, so port A wins a collision.
    always_ff @(posedge clk) begin
        if (b_wr_en && !rst) begin
            mem[ptr] <= b_in_data;
        end
        if (a_cs && a_we) begin
            mem[a_addr] <= a_din;
        end
    end

    // Port A read: read-first registered output with a one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout  <= '0;
            a_valid <= 1'b0;
        end else begin
            a_valid <= a_cs && !a_we;
            if (a_cs && !a_we) begin
                a_dout <= mem[a_addr];
            end
        end
    end

    // Port B read data register: loaded in RD_FETCH, held through RD_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_out_data <= '0;
        end else if (b_rd_en) begin
            b_out_data <= mem[ptr];
        end
    end

    // Port B control registers: state, pointer, remaining count, direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            dir   <= dir_n;
        end
    end

    // Port B next-state logic and Moore-style handshake outputs.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        dir_n       = dir;
        b_rd_en     = 1'b0;
        b_wr_en     = 1'b0;
        b_in_ready  = 1'b0;
        b_out_valid = 1'b0;
        b_busy      = 1'b1;
        b_done      = 1'b0;

        case (state)
            IDLE: begin
                b_busy = 1'b0;
                if (b_start) begin
                    ptr_n = b_base;
                    cnt_n = b_len;
                    dir_n = b_dir;
                    if (b_len == '0) begin
                        state_n = DONE;
                    end else if (b_dir) begin
                        state_n = WR;
                    end else begin
                        state_n = RD_FETCH;
                    end
                end
            end

            RD_FETCH: begin
                b_rd_en = 1'b1;
                state_n = RD_HOLD;
            end

            RD_HOLD: begin
                b_out_valid = 1'b1;
                if (b_out_ready) begin
                    ptr_n   = ptr + ADDR_W'(1);
                    cnt_n   = cnt - (ADDR_W+1)'(1);
                    state_n = last_word ? DONE : RD_FETCH;
                end
            end

            WR: begin
                b_in_ready = 1'b1;
                if (b_in_valid) begin
                    b_wr_en = 1'b1;
                    ptr_n   = ptr + ADDR_W'(1);
                    cnt_n   = cnt - (ADDR_W+1)'(1);
                    if (last_word) begin
                        state_n = DONE;
                    end
                end
            end

            DONE: begin
                b_done  = 1'b1;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sector_buffer_ram.sv
// Bench for sector_buffer_ram: directed vectors, expected-data queues,
// and monitors that pop and compare whenever the DUT presents output.
module tb_sector_buffer_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic              a_cs = 1'b0;
    logic              a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_din = '0;
    logic [DATA_W-1:0] a_dout;
    logic              a_valid;
    logic              b_start = 1'b0;
    logic              b_dir = 1'b0;
    logic [ADDR_W-1:0] b_base = '0;
    logic [ADDR_W:0]   b_len = '0;
    logic [DATA_W-1:0] b_in_data = '0;
    logic              b_in_valid = 1'b0;
    logic              b_in_ready;
    logic [DATA_W-1:0] b_out_data;
    logic              b_out_valid;
    logic              b_out_ready = 1'b0;
    logic              b_busy;
    logic              b_done;

    sector_buffer_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_valid(a_valid),
        .b_start(b_start), .b_dir(b_dir), .b_base(b_base), .b_len(b_len),
        .b_in_data(b_in_data), .b_in_valid(b_in_valid), .b_in_ready(b_in_ready),
        .b_out_data(b_out_data), .b_out_valid(b_out_valid), .b_out_ready(b_out_ready),
        .b_busy(b_busy), .b_done(b_done)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0] a_exp_q[$];
    int                a_due_q[$];
    logic [DATA_W-1:0] b_exp_q[$];
    int                b_obs_cyc[$];
    int                done_cnt = 0;
    int                done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Port A monitor: every a_valid must match the oldest outstanding read.
    logic [DATA_W-1:0] a_pop_d;
    int                a_pop_c;
    always @(negedge clk) begin
        if (!rst && a_valid) begin
            if (a_exp_q.size() == 0) begin
                check("a_spurious_valid", 32'd1, 32'd0);
            end else begin
                a_pop_d = a_exp_q.pop_front();
                a_pop_c = a_due_q.pop_front();
                check("a_rdata", 32'(a_dout), 32'(a_pop_d));
                check("a_latency", 32'(cyc), 32'(a_pop_c));
            end
        end
    end

    // Port B stream monitor: every accepted output word must match in order.
    logic [DATA_W-1:0] b_pop_d;
    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            b_obs_cyc.push_back(cyc);
            if (b_exp_q.size() == 0) begin
                check("b_spurious_xfer", 32'd1, 32'd0);
            end else begin
                b_pop_d = b_exp_q.pop_front();
                check("b_out_data", 32'(b_out_data), 32'(b_pop_d));
            end
        end
    end

    // Done pulse recorder.
    always @(negedge clk) begin
        if (!rst && b_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        a_cs = 1'b1; a_we = 1'b1; a_addr = addr; a_din = data;
        step();
        a_cs = 1'b0; a_we = 1'b0;
    endtask

    task automatic a_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        a_exp_q.push_back(exp);
        a_due_q.push_back(cyc + 1);
        a_cs = 1'b1; a_we = 1'b0; a_addr = addr;
        step();
        a_cs = 1'b0;
    endtask

    task automatic start_stream(input logic dir, input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
        b_start = 1'b1; b_dir = dir; b_base = base; b_len = len;
        step();
        b_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && b_busy; i++) step();
        check(name, 32'(b_busy), 32'd0);
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int d0;
    initial begin
        // Reset state
        repeat (3) step();
        check("rst_a_dout", 32'(a_dout), 32'd0);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        check("rst_b_done", 32'(b_done), 32'd0);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        check("rst_b_in_ready", 32'(b_in_ready), 32'd0);
        check("rst_b_out_data", 32'(b_out_data), 32'd0);
        rst = 1'b0;
        step();

        // Port A basic write/read
        a_write(13'h0010, 8'hA5);
        a_read(13'h0010, 8'hA5);
        repeat (2) step();

        // Stream read of four words at full rate
        a_write(13'h0100, 8'h11);
        a_write(13'h0101, 8'h22);
        a_write(13'h0102, 8'h33);
        a_write(13'h0103, 8'h44);
        b_exp_q.push_back(8'h11); b_exp_q.push_back(8'h22);
        b_exp_q.push_back(8'h33); b_exp_q.push_back(8'h44);
        b_obs_cyc.delete();
        d0 = done_cnt;
        b_out_ready = 1'b1;
        start_stream(1'b0, 13'h0100, 14'd4);
        check("rd_busy_after_start", 32'(b_busy), 32'd1);
        wait_idle("rd_timeout", 50);
        check("rd_xfer_count", 32'(b_obs_cyc.size()), 32'd4);
        if (b_obs_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("rd_spacing", 32'(b_obs_cyc[i] - b_obs_cyc[i-1]), 32'd2);
            check("rd_done_timing", 32'(done_cyc), 32'(b_obs_cyc[3] + 1));
        end
        check("rd_done_count", 32'(done_cnt), 32'(d0 + 1));
        b_out_ready = 1'b0;
        step();

        // Write stream with input gaps, wrapping past the top address
        start_stream(1'b1, 13'h1FFE, 14'd4);
        for (int i = 1; i <= 4; i++) begin
            b_in_valid = 1'b0;
            step();
            b_in_valid = 1'b1;
            b_in_data  = 8'(i);
            check("wr_in_ready", 32'(b_in_ready), 32'd1);
            step();
        end
        b_in_valid = 1'b0;
        wait_idle("wr_timeout", 20);
        a_read(13'h1FFE, 8'h01);
        a_read(13'h1FFF, 8'h02);
        a_read(13'h0000, 8'h03);
        a_read(13'h0001, 8'h04);
        repeat (2) step();

        // Read back the wrapped range with consumer backpressure
        b_exp_q.push_back(8'h01); b_exp_q.push_back(8'h02);
        b_exp_q.push_back(8'h03); b_exp_q.push_back(8'h04);
        start_stream(1'b0, 13'h1FFE, 14'd4);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(b_out_valid), 32'd1);
            check("bp_out_data", 32'(b_out_data), 32'h01);
            step();
        end
        b_out_ready = 1'b1;
        wait_idle("bp_timeout", 30);
        b_out_ready = 1'b0;
        step();

        // Zero-length transfer: straight to DONE, RAM untouched
        a_write(13'h0200, 8'h5A);
        d0 = done_cnt;
        b_in_valid = 1'b1;
        b_in_data  = 8'hEE;
        start_stream(1'b1, 13'h0200, 14'd0);
        check("zl_done", 32'(b_done), 32'd1);
        check("zl_busy", 32'(b_busy), 32'd1);
        check("zl_in_ready", 32'(b_in_ready), 32'd0);
        check("zl_out_valid", 32'(b_out_valid), 32'd0);
        step();
        check("zl_done_clear", 32'(b_done), 32'd0);
        check("zl_idle", 32'(b_busy), 32'd0);
        b_in_valid = 1'b0;
        check("zl_done_count", 32'(done_cnt), 32'(d0 + 1));
        a_read(13'h0200, 8'h5A);
        repeat (2) step();

        // b_start pulsed mid-transfer is ignored
        a_write(13'h0300, 8'h31);
        a_write(13'h0301, 8'h32);
        a_write(13'h0302, 8'h33);
        a_write(13'h0303, 8'h34);
        b_exp_q.push_back(8'h31); b_exp_q.push_back(8'h32);
        b_exp_q.push_back(8'h33); b_exp_q.push_back(8'h34);
        b_obs_cyc.delete();
        d0 = done_cnt;
        b_out_ready = 1'b1;
        start_stream(1'b0, 13'h0300, 14'd4);
        step();
        start_stream(1'b1, 13'h0100, 14'd1);
        wait_idle("ign_timeout", 50);
        check("ign_xfer_count", 32'(b_obs_cyc.size()), 32'd4);
        check("ign_done_count", 32'(done_cnt), 32'(d0 + 1));
        step();
        check("ign_stays_idle", 32'(b_busy), 32'd0);
        b_out_ready = 1'b0;

        // Write collision: port A wins
        start_stream(1'b1, 13'h0050, 14'd1);
        b_in_valid = 1'b1;
        b_in_data  = 8'h55;
        a_write(13'h0050, 8'hAA);
        b_in_valid = 1'b0;
        wait_idle("col_timeout", 10);
        a_read(13'h0050, 8'hAA);
        repeat (2) step();

        // Port A read concurrent with a port B write to the same address
        start_stream(1'b1, 13'h0050, 14'd1);
        b_in_valid = 1'b1;
        b_in_data  = 8'h77;
        a_read(13'h0050, 8'hAA);
        b_in_valid = 1'b0;
        wait_idle("rf_timeout", 10);
        a_read(13'h0050, 8'h77);
        repeat (2) step();

        // Reset during an 8-word read after three words
        for (int i = 0; i < 8; i++) a_write(13'(13'h0400 + i), 8'(8'h80 + i));
        b_exp_q.push_back(8'h80); b_exp_q.push_back(8'h81); b_exp_q.push_back(8'h82);
        b_obs_cyc.delete();
        d0 = done_cnt;
        b_out_ready = 1'b1;
        start_stream(1'b0, 13'h0400, 14'd8);
        for (int i = 0; i < 100 && b_obs_cyc.size() < 3; i++) step();
        check("rst_mid_words", 32'(b_obs_cyc.size()), 32'd3);
        rst = 1'b1;
        b_out_ready = 1'b0;
        step();
        check("rst_mid_busy", 32'(b_busy), 32'd0);
        check("rst_mid_out_valid", 32'(b_out_valid), 32'd0);
        check("rst_mid_done", 32'(b_done), 32'd0);
        step();
        rst = 1'b0;
        b_out_ready = 1'b1;
        repeat (5) step();
        check("rst_mid_no_done", 32'(done_cnt), 32'(d0));
        check("rst_mid_still_idle", 32'(b_busy), 32'd0);
        b_out_ready = 1'b0;
        a_read(13'h0403, 8'h83);
        a_read(13'h0100, 8'h11);
        a_read(13'h0010, 8'hA5);
        repeat (4) step();

        // All expected responses consumed
        check("a_queue_empty", 32'(a_exp_q.size()), 32'd0);
        check("b_queue_empty", 32'(b_exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
